// File: rtl/fir_tap_multiplier_if.sv
// Sample/coefficient input stream and per-tap product output bundle
// of the FIR tap multiplier front end.
interface fir_tap_multiplier_if #(
  parameter int TAPS     = 401,
  parameter int DATABITS = 16,
  parameter int COEFBITS = 16,
  parameter int MULTBITS = 32
);
  logic [DATABITS-1:0]            sample_in;
  logic                           sample_valid;
  logic                           sample_ready;
  logic                           flush;
  logic                           coef_start;
  logic [COEFBITS-1:0]            coef_in;
  logic                           coef_valid;
  logic                           coef_loaded;
  logic [TAPS-1:0][MULTBITS-1:0]  mult_out;   // mult_out[k] = x[n-k]*h[k]
  logic                           out_valid;

  // Upstream source / product consumer side
  modport master (
    output sample_in, sample_valid, flush, coef_start, coef_in, coef_valid,
    input  sample_ready, coef_loaded, mult_out, out_valid
  );

  // The tap multiplier itself
  modport slave (
    input  sample_in, sample_valid, flush, coef_start, coef_in, coef_valid,
    output sample_ready, coef_loaded, mult_out, out_valid
  );
endinterface

// File: rtl/fir_tap_multiplier.sv
// FIR front end: sample delay line, sequentially loaded coefficient bank
// and one registered full-precision signed product per tap.

// One tap: coefficient register plus registered product.
module fir_tap_lane #(
  parameter int DATABITS = 16,
  parameter int COEFBITS = 16,
  parameter int MULTBITS = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATABITS-1:0] x,
  input  logic                coef_we,
  input  logic [COEFBITS-1:0] coef_in,
  input  logic                prod_en,
  output logic [MULTBITS-1:0] prod
);
  logic [COEFBITS-1:0] h;

  // Coefficient write from the load sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       h <= '0;
    else if (coef_we) h <= coef_in;
  end

  // Product register; sign-extend both operands so the low MULTBITS
  // bits hold the exact signed product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       prod <= '0;
    else if (prod_en) prod <= MULTBITS'($signed(x)) * MULTBITS'($signed(h));
  end
endmodule

module fir_tap_multiplier #(
  parameter int TAPS     = 401,
  parameter int DATABITS = 16,
  parameter int COEFBITS = 16,
  parameter int MULTBITS = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  fir_tap_multiplier_if.slave  bus
);
  localparam int AW     = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int STAGES = 1;   // accept -> product/out_valid register

  if (MULTBITS != DATABITS + COEFBITS) begin : g_bad_multbits
    $error("fir_tap_multiplier: MULTBITS must equal DATABITS+COEFBITS");
  end
  if (TAPS < 1) begin : g_bad_taps
    $error("fir_tap_multiplier: TAPS must be at least 1");
  end

  typedef enum logic {LOAD, RUN} state_t;

  state_t                        state;
  logic [AW-1:0]                 addr;
  logic                          coef_loaded;
  logic [TAPS-1:0][DATABITS-1:0] x_q;
  logic [TAPS-1:0][MULTBITS-1:0] prod;
  logic [STAGES:0]               vld_pipe;

  logic          accept;
  logic          coef_wr;
  logic [AW-1:0] wr_addr;
  logic          clr;

  // A start with a coefficient beat writes h[0] in the same cycle, so the
  // write address collapses to 0 whenever coef_start is high.
  assign wr_addr = bus.coef_start ? '0 : addr;
  assign coef_wr = bus.coef_valid && (bus.coef_start || state == LOAD);
  assign clr     = bus.coef_start || bus.flush;
  // coef_start outranks a sample presented in the same cycle.
  assign accept  = bus.sample_valid && (state == RUN) && !bus.flush && !bus.coef_start;

  // Load/run sequencer: coefficient address, state and loaded flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD;
      addr        <= '0;
      coef_loaded <= 1'b0;
    end else begin
      if (bus.coef_start) begin
        state       <= LOAD;
        addr        <= '0;
        coef_loaded <= 1'b0;
      end
      if (coef_wr) begin
        if (wr_addr == AW'(TAPS - 1)) begin
          state       <= RUN;
          addr        <= '0;
          coef_loaded <= 1'b1;
        end else begin
          addr <= wr_addr + 1'b1;
        end
      end
    end
  end

  // Delay line: clear on reload/flush, otherwise shift on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
    end else if (clr) begin
      x_q <= '0;
    end else if (accept) begin
      x_q[0] <= bus.sample_in;
      for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
    end
  end

  // Valid pipeline; an accept already registered always produces its
  // products, regardless of flush/coef_start arriving afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[STAGES-1:0], accept};
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    fir_tap_lane #(
      .DATABITS (DATABITS),
      .COEFBITS (COEFBITS),
      .MULTBITS (MULTBITS)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .x       (x_q[k]),
      .coef_we (coef_wr && (wr_addr == AW'(k))),
      .coef_in (bus.coef_in),
      .prod_en (vld_pipe[STAGES-1]),
      .prod    (prod[k])
    );
  end

  assign bus.mult_out     = prod;
  assign bus.out_valid    = vld_pipe[STAGES];
  assign bus.coef_loaded  = coef_loaded;
  assign bus.sample_ready = (state == RUN) && !bus.flush;
endmodule

// File: tb/tb_fir_tap_multiplier.sv
// Self-checking bench: directed test-plan scenarios plus random traffic,
// all checked against a transaction-level model of the tap multiplier.
module tb_fir_tap_multiplier;
  localparam int TAPS = 4;
  localparam int DB   = 16;
  localparam int CB   = 16;
  localparam int MB   = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_tap_multiplier_if #(.TAPS(TAPS), .DATABITS(DB), .COEFBITS(CB), .MULTBITS(MB)) bus ();

  fir_tap_multiplier #(.TAPS(TAPS), .DATABITS(DB), .COEFBITS(CB), .MULTBITS(MB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: newest sample first in hist, coefficient bank h
  int     m_hist[TAPS];
  int     m_h[TAPS];
  longint m_mult[TAPS];
  int     m_addr;
  bit     m_loaded;
  bit     m_pend;     // an accepted sample awaiting its products
  bit     m_vld;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin
      m_hist[k] = 0; m_h[k] = 0; m_mult[k] = 0;
    end
    m_addr = 0; m_loaded = 0; m_pend = 0; m_vld = 0;
  endtask

  // Apply one clock edge's worth of behaviour using the inputs just sampled.
  task automatic model_edge();
    bit acc, wr, cs, fl;
    int wa;
    cs = bus.coef_start;
    fl = bus.flush;
    // products of a previously accepted sample use pre-edge state
    if (m_pend)
      for (int k = 0; k < TAPS; k++) m_mult[k] = longint'(m_hist[k]) * longint'(m_h[k]);
    m_vld = m_pend;
    acc = bus.sample_valid && m_loaded && !fl && !cs;
    wr  = bus.coef_valid && (cs || !m_loaded);
    wa  = cs ? 0 : m_addr;
    if (cs || fl) begin
      for (int k = 0; k < TAPS; k++) m_hist[k] = 0;
    end else if (acc) begin
      for (int k = TAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = int'($signed(bus.sample_in));
    end
    if (cs) begin m_loaded = 0; m_addr = 0; end
    if (wr) begin
      m_h[wa] = int'($signed(bus.coef_in));
      if (wa == TAPS - 1) begin m_loaded = 1; m_addr = 0; end
      else m_addr = wa + 1;
    end
    m_pend = acc;
  endtask

  task automatic check_all();
    logic [31:0] e;
    chk("out_valid", bus.out_valid, m_vld);
    chk("coef_loaded", bus.coef_loaded, m_loaded);
    chk("sample_ready", bus.sample_ready, m_loaded && !bus.flush);
    for (int k = 0; k < TAPS; k++) begin
      e = m_mult[k][31:0];
      chk($sformatf("mult_out[%0d]", k), bus.mult_out[k], e);
    end
  endtask

  task automatic set(input bit sv, input int s, input bit fl, input bit cs, input bit cv, input int c);
    bus.sample_valid = sv;
    bus.sample_in    = 16'(s);
    bus.flush        = fl;
    bus.coef_start   = cs;
    bus.coef_valid   = cv;
    bus.coef_in      = 16'(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    check_all();
  endtask

  task automatic cyc(input bit sv, input int s, input bit fl, input bit cs, input bit cv, input int c);
    set(sv, s, fl, cs, cv, c);
    tick();
  endtask

  // Full coefficient load, starting with coef_start on the first beat
  task automatic load4(input int h0, input int h1, input int h2, input int h3);
    cyc(0, 0, 0, 1, 1, h0);
    cyc(0, 0, 0, 0, 1, h1);
    cyc(0, 0, 0, 0, 1, h2);
    cyc(0, 0, 0, 0, 1, h3);
    set(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set(0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_ready", bus.sample_ready, 0);
    chk("rst_loaded", bus.coef_loaded, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_mult", bus.mult_out, '0);
    rst_n = 1'b1;
  endtask

  initial begin
    set(0, 0, 0, 0, 0, 0);
    do_reset();

    // Impulse response
    load4(1, 2, 3, 4);
    chk("imp_loaded", bus.coef_loaded, 1);
    chk("imp_ready", bus.sample_ready, 1);
    cyc(1, 1, 0, 0, 0, 0);
    chk("imp_ov_lat", bus.out_valid, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("imp_ov0", bus.out_valid, 1);
    chk("imp_p0", bus.mult_out, {32'd0, 32'd0, 32'd0, 32'd1});
    cyc(1, 0, 0, 0, 0, 0);
    chk("imp_p1", bus.mult_out, {32'd0, 32'd0, 32'd2, 32'd0});
    cyc(1, 0, 0, 0, 0, 0);
    chk("imp_p2", bus.mult_out, {32'd0, 32'd3, 32'd0, 32'd0});
    cyc(0, 0, 0, 0, 0, 0);
    chk("imp_p3", bus.mult_out, {32'd4, 32'd0, 32'd0, 32'd0});
    chk("imp_ov3", bus.out_valid, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("imp_ov_end", bus.out_valid, 0);

    // Not loaded: sample_valid held through a partial load
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1, 7, 0, 0, 1, i + 1);
      chk("nl_ready", bus.sample_ready, 0);
      chk("nl_ov", bus.out_valid, 0);
    end
    cyc(1, 7, 0, 0, 1, 4);
    chk("nl_loaded4", bus.coef_loaded, 1);
    chk("nl_ready4", bus.sample_ready, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // Signed extremes
    do_reset();
    load4(-32768, 0, 0, 0);
    cyc(1, -32768, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("sx_min", bus.mult_out[0], 32'h4000_0000);
    load4(-1, 0, 0, 0);
    cyc(1, 32767, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("sx_neg", bus.mult_out[0], 32'hFFFF_8001);

    // Reload mid-stream
    load4(1, 2, 3, 4);
    cyc(1, 5, 0, 0, 0, 0);
    cyc(1, 6, 0, 0, 0, 0);
    cyc(1, 7, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 9);
    chk("rl_ov", bus.out_valid, 1);
    chk("rl_inflight", bus.mult_out, {32'd0, 32'd15, 32'd12, 32'd7});
    chk("rl_ready", bus.sample_ready, 0);
    chk("rl_loaded", bus.coef_loaded, 0);
    cyc(0, 0, 0, 0, 1, 2);
    cyc(0, 0, 0, 0, 1, 3);
    chk("rl_addr_pre", bus.coef_loaded, 0);
    cyc(0, 0, 0, 0, 1, 4);
    chk("rl_addr_done", bus.coef_loaded, 1);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rl_zeroed", bus.mult_out, {32'd0, 32'd0, 32'd0, 32'd9});

    // Flush
    load4(1, 1, 1, 1);
    cyc(1, 2, 0, 0, 0, 0);
    cyc(1, 3, 0, 0, 0, 0);
    set(1, 4, 1, 0, 0, 0);
    #1;
    chk("fl_ready", bus.sample_ready, 0);
    tick();
    chk("fl_inflight", bus.out_valid, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("fl_noacc", bus.out_valid, 0);
    cyc(1, 8, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("fl_after", bus.mult_out, {32'd0, 32'd0, 32'd0, 32'd8});

    // Random traffic
    load4($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
          $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768);
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 99) < 70, $urandom_range(0, 65535) - 32768,
          $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 3,
          $urandom_range(0, 99) < 60, $urandom_range(0, 65535) - 32768);
    end

    // Asynchronous reset mid-stream, between edges
    set(0, 0, 0, 0, 0, 0);
    load4(1, 2, 3, 4);
    cyc(1, 100, 0, 0, 0, 0);
    cyc(1, -5, 0, 0, 0, 0);
    chk("ar_pre_ov", bus.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_ready", bus.sample_ready, 0);
    chk("ar_loaded", bus.coef_loaded, 0);
    chk("ar_ov", bus.out_valid, 0);
    chk("ar_mult", bus.mult_out, '0);
    set(0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1, 3, 0, 0, 0, 0);
    chk("ar_post_loaded", bus.coef_loaded, 0);
    chk("ar_post_ov", bus.out_valid, 0);
    load4(2, 0, 0, 0);
    cyc(1, 3, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("ar_recover", bus.mult_out[0], 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
